tmds_channel_encoder: RTL and testbench



---
 rtl/hdmi_tmds_pkg.sv | 64 ++++++
 rtl/tmds_qm_stage.sv | 67 ++++++
 rtl/tmds_channel_encoder.sv | 117 +++++++++++
 tb/tb_tmds_channel_encoder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_tmds_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_tmds_pkg
// Shared definitions for the HDMI TMDS lane encoder:
//   - MODE_* : period-mode encodings presented on i_mode
//   - CTRL_CODE[0:3] : control-period codewords indexed by {c1,c0}
//   - VGB_CODE_EVEN / VGB_CODE_ODD / DGB_CODE : guard-band codewords
//   - terc4_code() : TERC4 nibble-to-symbol lookup (data islands)
//   - popcount8()  : number of ones in a byte
// All codewords are written as o_tmds[9:0]; bit 0 is serialised first.
// ---------------------------------------------------------------------------
package hdmi_tmds_pkg;

    localparam logic [2:0] MODE_CTRL  = 3'd0;
    localparam logic [2:0] MODE_VIDEO = 3'd1;
    localparam logic [2:0] MODE_TERC4 = 3'd2;
    localparam logic [2:0] MODE_VGB   = 3'd3;
    localparam logic [2:0] MODE_DGB   = 3'd4;

    localparam logic [9:0] CTRL_CODE [0:3] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    // Video guard band: lanes 0 and 2 share one word, lane 1 uses its complement.
    localparam logic [9:0] VGB_CODE_EVEN = 10'b1011001100;
    localparam logic [9:0] VGB_CODE_ODD  = 10'b0100110011;
    // Data-island guard band on lanes 1 and 2; lane 0 carries TERC4 instead.
    localparam logic [9:0] DGB_CODE      = 10'b0100110011;

    function automatic logic [9:0] terc4_code(input logic [3:0] nibble);
        logic [9:0] code;
        case (nibble)
            4'h0:    code = 10'b1010011100;
            4'h1:    code = 10'b1001100011;
            4'h2:    code = 10'b1011100100;
            4'h3:    code = 10'b1011100010;
            4'h4:    code = 10'b0101110001;
            4'h5:    code = 10'b0100011110;
            4'h6:    code = 10'b0110001110;
            4'h7:    code = 10'b0100111100;
            4'h8:    code = 10'b1011001100;
            4'h9:    code = 10'b0100111001;
            4'hA:    code = 10'b0110011100;
            4'hB:    code = 10'b1011000110;
            4'hC:    code = 10'b1010001110;
            4'hD:    code = 10'b1001110001;
            4'hE:    code = 10'b0101100011;
            default: code = 10'b1011000011;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// ---------------------------------------------------------------------------
// tmds_qm_stage
// Stage 1 of the TMDS lane encoder: transition-minimised word q_m[8:0]
// computed from the video byte, registered together with the (normalised)
// mode, control bits and TERC4 nibble so stage 2 sees one aligned symbol.
// Ports:
//   i_pixclk, i_reset_n, i_ce     clock, async active-low reset, clock enable
//   i_mode[2:0]                   period mode; 5..7 are stored as CTRL
//   i_data[7:0], i_ctrl[1:0], i_terc4[3:0]   per-mode payloads
//   o_qm[8:0]                     registered q_m (bit 8 = 1 for XOR chain)
//   o_mode, o_ctrl, o_terc4       registered side-band for stage 2
// ---------------------------------------------------------------------------
module tmds_qm_stage
    import hdmi_tmds_pkg::*;
(
    input  logic       i_pixclk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic [2:0] i_mode,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic [3:0] i_terc4,
    output logic [8:0] o_qm,
    output logic [2:0] o_mode,
    output logic [1:0] o_ctrl,
    output logic [3:0] o_terc4
);

    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm_d;
    logic [2:0] mode_d;

    // NOTE: every signal written here gets a value before any condition,
    // so no path through the block leaves it unassigned (no latch).
    always_comb begin
        qm_d     = '0;
        n1       = popcount8(i_data);
        // XNOR chain when the byte is ones-heavy; ties broken on D[0].
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !i_data[0]);
        qm_d[0]  = i_data[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ i_data[i]) : (qm_d[i-1] ^ i_data[i]);
        end
        qm_d[8]  = ~use_xnor;
    end

    // Unused mode values collapse to CTRL here so stage 2 decodes five cases.
    assign mode_d = (i_mode > MODE_DGB) ? MODE_CTRL : i_mode;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_qm    <= '0;
            o_mode  <= MODE_CTRL;
            o_ctrl  <= 2'b00;
            o_terc4 <= '0;
        end else if (i_ce) begin
            o_qm    <= qm_d;
            o_mode  <= mode_d;
            o_ctrl  <= i_ctrl;
            o_terc4 <= i_terc4;
        end
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// ---------------------------------------------------------------------------
// tmds_channel_encoder
// Single-lane HDMI TMDS encoder: video 8b/10b with DC balance, control,
// TERC4 data island and video/data-island guard bands. Two enabled cycles
// from inputs to o_tmds. One instance per lane (CHANNEL 0..2).
// Parameters:
//   CHANNEL  lane index 0..2, selects guard-band codewords
//   CNT_W    signed running-disparity width (>= 5)
// Ports:
//   i_pixclk, i_reset_n, i_ce     clock, async active-low reset, clock enable
//   i_mode[2:0]                   0 CTRL, 1 VIDEO, 2 TERC4, 3 VGB, 4 DGB
//   i_data[7:0]                   video byte
//   i_ctrl[1:0]                   control bits {c1,c0}
//   i_terc4[3:0]                  TERC4 nibble (also DGB payload on lane 0)
//   o_tmds[9:0]                   registered symbol, bit 0 sent first
//   o_disp[CNT_W-1:0]             running disparity (debug)
// ---------------------------------------------------------------------------
module tmds_channel_encoder
    import hdmi_tmds_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int CNT_W   = 5
) (
    input  logic             i_pixclk,
    input  logic             i_reset_n,
    input  logic             i_ce,
    input  logic [2:0]       i_mode,
    input  logic [7:0]       i_data,
    input  logic [1:0]       i_ctrl,
    input  logic [3:0]       i_terc4,
    output logic [9:0]       o_tmds,
    output logic [CNT_W-1:0] o_disp
);

    localparam logic signed [CNT_W-1:0] DISP_LIMIT = CNT_W'(10);

    logic [8:0] qm_s1;
    logic [2:0] mode_s1;
    logic [1:0] ctrl_s1;
    logic [3:0] terc4_s1;

    tmds_qm_stage u_qm_stage (
        .i_pixclk  (i_pixclk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_mode    (i_mode),
        .i_data    (i_data),
        .i_ctrl    (i_ctrl),
        .i_terc4   (i_terc4),
        .o_qm      (qm_s1),
        .o_mode    (mode_s1),
        .o_ctrl    (ctrl_s1),
        .o_terc4   (terc4_s1)
    );

    logic [9:0]              tmds_q, tmds_d;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]              n1, n0;
    logic signed [CNT_W-1:0] n1_s, n0_s, q8_x2, nq8_x2;
    logic                    q8;
    logic                    cnt_pos, cnt_neg;

    always_comb begin
        tmds_d  = CTRL_CODE[ctrl_s1];
        cnt_d   = '0;
        q8      = qm_s1[8];
        n1      = popcount8(qm_s1[7:0]);
        n0      = 4'd8 - n1;
        n1_s    = CNT_W'(n1);
        n0_s    = CNT_W'(n0);
        q8_x2   = q8 ? CNT_W'(2) : '0;
        nq8_x2  = q8 ? '0 : CNT_W'(2);
        // Sign bit tests keep the comparisons signed at any CNT_W.
        cnt_neg = cnt_q[CNT_W-1];
        cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != '0);

        case (mode_s1)
            MODE_VIDEO: begin
                if ((cnt_q == '0) || (n1 == n0)) begin
                    tmds_d = {~q8, q8, q8 ? qm_s1[7:0] : ~qm_s1[7:0]};
                    cnt_d  = q8 ? (cnt_q + (n1_s - n0_s)) : (cnt_q + (n0_s - n1_s));
                end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
                    // Invert to pull the running disparity back toward zero.
                    tmds_d = {1'b1, q8, ~qm_s1[7:0]};
                    cnt_d  = cnt_q + q8_x2 + (n0_s - n1_s);
                end else begin
                    tmds_d = {1'b0, q8, qm_s1[7:0]};
                    cnt_d  = cnt_q - nq8_x2 + (n1_s - n0_s);
                end
            end
            MODE_TERC4: tmds_d = terc4_code(terc4_s1);
            MODE_VGB:   tmds_d = (CHANNEL == 1) ? VGB_CODE_ODD : VGB_CODE_EVEN;
            // Lane 0 keeps carrying {1,1,vsync,hsync} as TERC4 in the guard band.
            MODE_DGB:   tmds_d = (CHANNEL == 0) ? terc4_code(terc4_s1) : DGB_CODE;
            default:    tmds_d = CTRL_CODE[ctrl_s1];
        endcase
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmds_q <= CTRL_CODE[0];
            cnt_q  <= '0;
        end else if (i_ce) begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_tmds = tmds_q;
    assign o_disp = cnt_q;

    // The 8b/10b algorithm keeps disparity within +/-10; anything outside
    // means the counter has wrapped.
    a_disp_bounded: assert property (@(posedge i_pixclk) disable iff (!i_reset_n)
        (cnt_q <= DISP_LIMIT) && (cnt_q >= -DISP_LIMIT));

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_channel_encoder
// Drives three lane instances (CHANNEL 0, 1, 2) from shared inputs and
// compares them each cycle with a behavioural reference that encodes each
// symbol straight from the TMDS rules (prefix-parity q_m, integer disparity).
// ---------------------------------------------------------------------------
module tb_tmds_channel_encoder;

    localparam logic [2:0] M_CTRL  = 3'd0;
    localparam logic [2:0] M_VIDEO = 3'd1;
    localparam logic [2:0] M_TERC4 = 3'd2;
    localparam logic [2:0] M_VGB   = 3'd3;
    localparam logic [2:0] M_DGB   = 3'd4;

    localparam logic [9:0] CTRL_TAB [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    localparam logic [9:0] GB_02 = 10'b1011001100;
    localparam logic [9:0] GB_1  = 10'b0100110011;

    typedef struct packed {
        logic [2:0] mode;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic [3:0] terc4;
    } sym_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b1;
    logic [2:0] mode = M_CTRL;
    logic [7:0] data = '0;
    logic [1:0] ctrl = '0;
    logic [3:0] terc4 = '0;

    logic [9:0]        tmds0, tmds1, tmds2;
    logic signed [4:0] disp0, disp1, disp2;
    logic [9:0]         obs_tmds [3];
    logic signed [31:0] obs_disp [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    sym_t       m_s1;
    logic [9:0] exp_tmds [3];
    int         exp_cnt;
    bit         exp_video;
    logic [7:0] exp_byte;

    always #5 clk = ~clk;

    tmds_channel_encoder #(.CHANNEL(0), .CNT_W(5)) u_dut0 (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_terc4(terc4), .o_tmds(tmds0), .o_disp(disp0));
    tmds_channel_encoder #(.CHANNEL(1), .CNT_W(5)) u_dut1 (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_terc4(terc4), .o_tmds(tmds1), .o_disp(disp1));
    tmds_channel_encoder #(.CHANNEL(2), .CNT_W(5)) u_dut2 (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_terc4(terc4), .o_tmds(tmds2), .o_disp(disp2));

    assign obs_tmds[0] = tmds0;
    assign obs_tmds[1] = tmds1;
    assign obs_tmds[2] = tmds2;
    assign obs_disp[0] = disp0;
    assign obs_disp[1] = disp1;
    assign obs_disp[2] = disp2;

    // Encode one symbol for lane ch from the spec rules.
    task automatic model_symbol(input sym_t s, input int ch, input int cnt_in,
                                output logic [9:0] code, output int cnt_out);
        logic [7:0] q, mask;
        int n1, ones, diff, q8;
        bit use_xnor;
        cnt_out = 0;
        case (s.mode)
            M_VIDEO: begin
                n1 = $countones(s.data);
                use_xnor = (n1 > 4) || (n1 == 4 && s.data[0] == 1'b0);
                // q[i] = parity(D[0..i]), flipped on odd i for the XNOR chain
                for (int i = 0; i < 8; i++) begin
                    mask = 8'((16'h1 << (i + 1)) - 1);
                    q[i] = 1'(($countones(s.data & mask) % 2) ^ ((use_xnor && (i % 2 == 1)) ? 1 : 0));
                end
                q8   = use_xnor ? 0 : 1;
                ones = $countones(q);
                diff = 2 * ones - 8;
                if (cnt_in == 0 || diff == 0) begin
                    code    = (q8 == 1) ? {2'b01, q} : {2'b10, ~q};
                    cnt_out = cnt_in + ((q8 == 1) ? diff : -diff);
                end else if ((cnt_in > 0 && diff > 0) || (cnt_in < 0 && diff < 0)) begin
                    code    = {1'b1, 1'(q8), ~q};
                    cnt_out = cnt_in + 2 * q8 - diff;
                end else begin
                    code    = {1'b0, 1'(q8), q};
                    cnt_out = cnt_in - 2 * (1 - q8) + diff;
                end
            end
            M_TERC4: code = TERC4_TAB[s.terc4];
            M_VGB:   code = (ch == 1) ? GB_1 : GB_02;
            M_DGB:   code = (ch == 0) ? TERC4_TAB[s.terc4] : GB_1;
            default: code = CTRL_TAB[s.ctrl];
        endcase
    endtask

    function automatic logic [7:0] tmds_decode(input logic [9:0] c);
        logic [7:0] w, d;
        w = c[9] ? ~c[7:0] : c[7:0];
        d[0] = w[0];
        for (int i = 1; i < 8; i++) d[i] = w[i] ^ w[i-1] ^ ~c[8];
        return d;
    endfunction

    task automatic model_reset();
        m_s1      = '0;
        for (int ch = 0; ch < 3; ch++) exp_tmds[ch] = CTRL_TAB[0];
        exp_cnt   = 0;
        exp_video = 1'b0;
        exp_byte  = '0;
    endtask

    // Present one symbol, take one clock edge, advance the model if enabled.
    task automatic cycle(input logic c, input logic [2:0] m, input logic [7:0] d,
                         input logic [1:0] k, input logic [3:0] t);
        logic [9:0] code;
        int nc;
        ce = c; mode = m; data = d; ctrl = k; terc4 = t;
        @(posedge clk);
        #1;
        if (c) begin
            nc = 0;
            for (int ch = 0; ch < 3; ch++) begin
                model_symbol(m_s1, ch, exp_cnt, code, nc);
                exp_tmds[ch] = code;
            end
            exp_cnt   = nc;
            exp_video = (m_s1.mode == M_VIDEO);
            exp_byte  = m_s1.data;
            m_s1      = '{mode: m, data: d, ctrl: k, terc4: t};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce = 1'b1; mode = M_CTRL; data = '0; ctrl = '0; terc4 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        for (int ch = 0; ch < 3; ch++) begin
            n_checks++;
            if (obs_tmds[ch] !== 10'h354 || obs_disp[ch] !== 0) begin
                n_fail++;
                $display("FAIL reset_async ch%0d: got %h/%0d expected 354/0", ch, obs_tmds[ch], obs_disp[ch]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, M_CTRL, 8'h00, 2'b00, 4'h0);
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== 10'h354 || obs_disp[ch] !== 0) begin
                    n_fail++;
                    $display("FAIL reset_idle ch%0d: got %h/%0d expected 354/0", ch, obs_tmds[ch], obs_disp[ch]);
                end
            end
        end
    endtask

    task automatic test_video_dc();
        logic [9:0] want_t [3] = '{10'h100, 10'h3FF, 10'h100};
        int         want_d [3] = '{-8, 2, -6};
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, (k <= 3) ? M_VIDEO : M_CTRL, 8'h00, 2'b00, 4'h0);
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== exp_tmds[ch] || obs_disp[ch] !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL video_dc_model k%0d ch%0d: got %h/%0d expected %h/%0d",
                             k, ch, obs_tmds[ch], obs_disp[ch], exp_tmds[ch], exp_cnt);
                end
                if (k >= 2 && k <= 4) begin
                    n_checks++;
                    if (obs_tmds[ch] !== want_t[k-2] || obs_disp[ch] !== want_d[k-2]) begin
                        n_fail++;
                        $display("FAIL video_dc_const k%0d ch%0d: got %h/%0d expected %h/%0d",
                                 k, ch, obs_tmds[ch], obs_disp[ch], want_t[k-2], want_d[k-2]);
                    end
                end
            end
        end
    endtask

    task automatic test_video_stream();
        logic [7:0] perm [256];
        logic [7:0] tmp, b;
        int j;
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        do_reset();
        for (int k = 0; k < 256 + 1500 + 2; k++) begin
            b = (k < 256) ? perm[k] : 8'($urandom);
            cycle(1'b1, (k < 256 + 1500) ? M_VIDEO : M_CTRL, b, 2'($urandom), 4'($urandom));
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== exp_tmds[ch] || obs_disp[ch] !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL video_stream k%0d ch%0d: got %h/%0d expected %h/%0d",
                             k, ch, obs_tmds[ch], obs_disp[ch], exp_tmds[ch], exp_cnt);
                end
            end
            if (exp_video) begin
                n_checks++;
                if (tmds_decode(obs_tmds[0]) !== exp_byte) begin
                    n_fail++;
                    $display("FAIL video_decode k%0d: got %h expected %h", k, tmds_decode(obs_tmds[0]), exp_byte);
                end
                n_checks++;
                if (obs_disp[0] > 10 || obs_disp[0] < -10) begin
                    n_fail++;
                    $display("FAIL video_bound k%0d: got %0d expected within +/-10", k, obs_disp[0]);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            if (k <= 6)       cycle(1'b1, M_VIDEO, 8'($urandom), 2'b00, 4'h0);
            else if (k == 7)  cycle(1'b1, M_TERC4, 8'($urandom), 2'b00, 4'h5);
            else if (k == 8)  cycle(1'b1, M_VIDEO, 8'h00, 2'b00, 4'h0);
            else              cycle(1'b1, M_CTRL, 8'h00, 2'b00, 4'h0);
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== exp_tmds[ch] || obs_disp[ch] !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL mode_switch_model k%0d ch%0d: got %h/%0d expected %h/%0d",
                             k, ch, obs_tmds[ch], obs_disp[ch], exp_tmds[ch], exp_cnt);
                end
            end
            if (k == 8) begin
                n_checks++;
                if (obs_tmds[0] !== 10'b0100011110 || obs_disp[0] !== 0) begin
                    n_fail++;
                    $display("FAIL mode_switch_terc4: got %h/%0d expected 11e/0", obs_tmds[0], obs_disp[0]);
                end
            end
            if (k == 9) begin
                n_checks++;
                if (obs_tmds[0] !== 10'h100 || obs_disp[0] !== -8) begin
                    n_fail++;
                    $display("FAIL mode_switch_video: got %h/%0d expected 100/-8", obs_tmds[0], obs_disp[0]);
                end
            end
        end
    endtask

    task automatic test_guard_bands();
        logic [9:0] want [4][3] = '{
            '{10'h2CC, 10'h133, 10'h2CC},   // VGB
            '{10'h28E, 10'h133, 10'h133},   // DGB, lane 0 TERC4 0xC
            '{10'h0AB, 10'h0AB, 10'h0AB},   // mode 7 -> CTRL 01
            '{10'h2AB, 10'h2AB, 10'h2AB}    // mode 5 -> CTRL 11
        };
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            case (k)
                1:       cycle(1'b1, M_VGB,  8'h5A, 2'b10, 4'h3);
                2:       cycle(1'b1, M_DGB,  8'h5A, 2'b10, 4'hC);
                3:       cycle(1'b1, 3'd7,   8'h5A, 2'b01, 4'h3);
                4:       cycle(1'b1, 3'd5,   8'h5A, 2'b11, 4'h3);
                default: cycle(1'b1, M_CTRL, 8'h00, 2'b00, 4'h0);
            endcase
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== exp_tmds[ch] || obs_disp[ch] !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL guard_model k%0d ch%0d: got %h/%0d expected %h/%0d",
                             k, ch, obs_tmds[ch], obs_disp[ch], exp_tmds[ch], exp_cnt);
                end
                if (k >= 2 && k <= 5) begin
                    n_checks++;
                    if (obs_tmds[ch] !== want[k-2][ch]) begin
                        n_fail++;
                        $display("FAIL guard_const k%0d ch%0d: got %h expected %h", k, ch, obs_tmds[ch], want[k-2][ch]);
                    end
                end
            end
        end
    endtask

    task automatic test_random_modes();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            cycle(1'b1, 3'($urandom_range(7, 0)), 8'($urandom), 2'($urandom), 4'($urandom));
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== exp_tmds[ch] || obs_disp[ch] !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL random_modes k%0d ch%0d: got %h/%0d expected %h/%0d",
                             k, ch, obs_tmds[ch], obs_disp[ch], exp_tmds[ch], exp_cnt);
                end
            end
        end
    endtask

    task automatic test_ce_and_reset();
        logic [9:0]         held_t [3];
        logic signed [31:0] held_d [3];
        do_reset();
        for (int k = 0; k < 20; k++) cycle(1'b1, M_VIDEO, 8'($urandom), 2'b00, 4'h0);
        for (int ch = 0; ch < 3; ch++) begin
            held_t[ch] = obs_tmds[ch];
            held_d[ch] = obs_disp[ch];
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 3'($urandom_range(4, 0)), 8'($urandom), 2'($urandom), 4'($urandom));
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== held_t[ch] || obs_disp[ch] !== held_d[ch]) begin
                    n_fail++;
                    $display("FAIL ce_hold k%0d ch%0d: got %h/%0d expected %h/%0d",
                             k, ch, obs_tmds[ch], obs_disp[ch], held_t[ch], held_d[ch]);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, M_VIDEO, 8'($urandom), 2'b00, 4'h0);
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== exp_tmds[ch] || obs_disp[ch] !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL ce_resume k%0d ch%0d: got %h/%0d expected %h/%0d",
                             k, ch, obs_tmds[ch], obs_disp[ch], exp_tmds[ch], exp_cnt);
                end
            end
        end
        // Reset asserted between edges must clear the outputs with no clock.
        #2 rst_n = 1'b0;
        #1;
        for (int ch = 0; ch < 3; ch++) begin
            n_checks++;
            if (obs_tmds[ch] !== 10'h354 || obs_disp[ch] !== 0) begin
                n_fail++;
                $display("FAIL async_reset ch%0d: got %h/%0d expected 354/0", ch, obs_tmds[ch], obs_disp[ch]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, M_VIDEO, 8'($urandom), 2'b00, 4'h0);
            for (int ch = 0; ch < 3; ch++) begin
                n_checks++;
                if (obs_tmds[ch] !== exp_tmds[ch] || obs_disp[ch] !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL post_reset k%0d ch%0d: got %h/%0d expected %h/%0d",
                             k, ch, obs_tmds[ch], obs_disp[ch], exp_tmds[ch], exp_cnt);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_video_dc();
        test_video_stream();
        test_mode_switch();
        test_guard_bands();
        test_random_modes();
        test_ce_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
